// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with a single-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic              sign_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   rem_q, quot_q;
    logic [XLEN-1:0]   result_q;
    logic              busy_q, done_q;

    // Operand decode at the request edge
    logic            is_div, a_signed, b_signed, a_neg, b_neg, sign_d;
    logic [XLEN-1:0] a_mag_d, b_mag_d, fast_res_d;
    logic            div_zero_d, div_ovf_d, fast_d;

    always_comb begin
        is_div = funct3[2];
        if (is_div) begin
            a_signed = ~funct3[0];
            b_signed = ~funct3[0];
        end else begin
            a_signed = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
            b_signed = (funct3[1:0] == 2'b01);
        end
        a_neg   = a_signed & rs1_val[XLEN-1];
        b_neg   = b_signed & rs2_val[XLEN-1];
        a_mag_d = a_neg ? -rs1_val : rs1_val;
        b_mag_d = b_neg ? -rs2_val : rs2_val;
        // REM follows the dividend's sign; everything else follows the sign product
        sign_d  = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);

        div_zero_d = is_div && (rs2_val == '0);
        div_ovf_d  = is_div && !funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                     && (rs2_val == '1);
        fast_d     = div_zero_d | div_ovf_d;
        if (div_zero_d) fast_res_d = funct3[1] ? rs1_val : '1;
        else            fast_res_d = funct3[1] ? '0 : rs1_val;
    end

    // One iteration step for each datapath
    logic [XLEN:0]     mul_sum_d;
    logic [XLEN:0]     div_shift_d;
    logic [XLEN-1:0]   div_diff_d;
    logic              div_ge_d;

    always_comb begin
        mul_sum_d   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
        div_shift_d = {rem_q, quot_q[XLEN-1]};
        div_ge_d    = div_shift_d >= {1'b0, b_q};
        // Remainder stays below the divisor, so the low XLEN bits hold the full difference
        div_diff_d  = div_shift_d[XLEN-1:0] - b_q;
    end

    // Sign correction and result select
    logic [2*XLEN-1:0] prod_fix_d;
    logic [XLEN-1:0]   quot_fix_d, rem_fix_d, fix_res_d;

    always_comb begin
        prod_fix_d = sign_q ? -prod_q : prod_q;
        quot_fix_d = sign_q ? -quot_q : quot_q;
        rem_fix_d  = sign_q ? -rem_q  : rem_q;
        case (op_q)
            3'b000:                 fix_res_d = prod_fix_d[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res_d = prod_fix_d[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res_d = quot_fix_d;
            default:                fix_res_d = rem_fix_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (fast_d) begin
                            result_q <= fast_res_d;
                            done_q   <= 1'b1;
                        end else begin
                            op_q    <= funct3;
                            a_q     <= a_mag_d;
                            b_q     <= b_mag_d;
                            sign_q  <= sign_d;
                            cnt_q   <= '0;
                            prod_q  <= {{XLEN{1'b0}}, b_mag_d};
                            rem_q   <= '0;
                            quot_q  <= a_mag_d;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        rem_q  <= div_ge_d ? div_diff_d : div_shift_d[XLEN-1:0];
                        quot_q <= {quot_q[XLEN-2:0], div_ge_d};
                    end else begin
                        prod_q <= {mul_sum_d, prod_q[XLEN-1:1]};
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) state_q <= FIX;
                end
                FIX: begin
                    result_q <= fix_res_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, random ops against an arithmetic
// model, and hand sequences for held start, back-to-back and mid-op reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic        busy, done;
    logic [31:0] result;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_last = '0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        logic [31:0] r;
        case (f)
            3'd0: begin p = 64'(ua * ub); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else begin p = 64'(sa / sb); r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                else begin p = 64'(sa % sb); r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Issue one op, deassert start after the sampling edge, wait for done
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_n,
                          output bit held);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b;
        lat = 0; busy_n = 0; held = 1'b1; res = 'x;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin res = result; break; end
            if (result !== exp_last) held = 1'b0;
        end
    endtask

    task automatic check_op(input string name, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        int lat, busy_n;
        bit held, fast;
        fast = is_fast(f, a, b);
        run_op(f, a, b, res, lat, busy_n, held);
        chk({name, "_res"}, res, exp);
        chk({name, "_lat"}, lat, fast ? 32'd1 : 32'd34);
        chk({name, "_busy"}, busy_n, fast ? 32'd0 : 32'd33);
        chk({name, "_hold"}, {31'b0, held}, 32'd1);
        exp_last = exp;
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int lat, lat2;
        bit nodone;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{3'b001, 32'h80000000,   32'h80000000, 32'h40000000};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,        32'd14};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,        32'd2};
        vecs[8]  = '{3'b101, 32'd5,          32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{3'b111, 32'd5,          32'd0,        32'd5};
        vecs[10] = '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'h0};

        rst_n = 1'b0; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0;
        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            check_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: begin a = -32'($urandom_range(0, 300)); b = $urandom_range(1, 20); end
                default: ;
            endcase
            check_op($sformatf("rnd%0d", i), f, a, b, ref_op(f, a, b));
        end

        // start held through the op with operands changed; then back-to-back accept
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7;
        @(posedge clk); #1;
        lat = 1;
        funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd5;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hold_lat", lat, 32'd34);
        chk("hold_res", result, 32'd14);
        chk("hold_busy_at_done", {31'b0, busy}, 32'd0);
        lat2 = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat2++;
            if (lat2 == 1) begin
                start = 1'b0;
                chk("b2b_busy", {31'b0, busy}, 32'd1);
            end
            if (done) break;
        end
        chk("b2b_lat", lat2, 32'd34);
        chk("b2b_res", result, 32'd15);

        // reset in the middle of a DIV
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; rs1_val = 32'hFFFFFFF9; rs2_val = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = '0;
        nodone = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) nodone = 1'b0;
        end
        chk("mid_rst_no_done", {31'b0, nodone}, 32'd1);
        chk("mid_rst_result_held", result, 32'd0);
        check_op("post_rst_mul", 3'b000, 32'd3, 32'd4, 32'd12);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit.
- Sits beside the ALU in the execute stage and directly downstream of the register file: it consumes the rs1/rs2 read values and returns a result for rd writeback.
- Multi-cycle operation with a start/busy/done handshake, so the core stalls while busy is high.
- One operation in flight at a time; no internal queueing.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only while idle (busy=0).
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  input  XLEN  operand A (multiplicand / dividend).
- rs2_val  input  XLEN  operand B (multiplier / divisor).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result valid that cycle.
- result  output  XLEN  registered result; held until the next done.

Behaviour:
- Clock is clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0.
- Reset asserted mid-operation aborts the operation immediately. No done is produced for it.
- States:
  - IDLE: waiting for start.
  - CALC: XLEN iterations.
  - FIX: sign correction and result register.
- IDLE + start, normal path (edge N):
  - latch funct3.
  - latch |A| and |B| as magnitudes, using signedness per op: MULH, DIV, REM take both operands signed; MULHSU takes A signed and B unsigned; the rest are unsigned.
  - latch the result sign flag.
  - counter=0, go to CALC, busy=1.
- IDLE + start, fast path (edge N): result is written directly, done=1 in cycle N+1, state stays IDLE, busy stays 0. Fast-path cases:
  - divisor==0: DIV/DIVU give all-ones; REM/REMU give rs1_val.
  - signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC, multiply: shift-add over a 2*XLEN product, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first. A remainder of XLEN+1 bits holds the trial subtract.
- CALC counter: increments each edge. On the edge where counter==XLEN-1, go to FIX.
- FIX (one edge):
  - negate the product if the operand signs differ (MUL*).
  - negate the quotient if the signs differ (DIV).
  - the remainder takes the dividend's sign (REM).
  - select result: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits; quotient for DIV*; remainder for REM*.
  - register result, done=1 for exactly one cycle, go to IDLE, busy=0 in the same cycle done is high.
- Normal latency: done is high in the cycle after edge N+XLEN+1 (34 cycles for XLEN=32). busy is high for cycles N+1 .. N+XLEN+1.
- start while busy: ignored. Operands and funct3 are not re-sampled.
- start in the cycle done=1: accepted (state is IDLE). Back-to-back operations are allowed with no bubble.
- All multiply ops take the full latency, including zero operands. No early-out.
- result does not change except on a done cycle or reset.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3): done exactly 34 cycles after start. result=0xFFFFFFEB. busy high 33 cycles.
- MULH 0x80000000,0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast path, 1-cycle done with busy never high:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Start held high and operands changed during CALC: result reflects the original operands. A second start in the done cycle begins a new op; its done arrives 34 cycles later.
- rst_n pulsed low at cycle 10 of a DIV: busy=0, done=0, result=0 asynchronously. No done follows. A fresh MUL 3x4 afterward -> 12.
